// File: rtl/rle_dec.sv
// Run-length expander: literals pass in 1 cycle, a count N emits N copies of the last literal.
// Input stalls (readyOut=0) while a run is expanding or the output slot is held by downstream backpressure.
module rle_dec #(
  parameter int CNT_W = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  disabledGroups,
  input  logic [31:0] dataIn,
  input  logic        validIn,
  output logic        readyOut,
  output logic [31:0] dataOut,
  output logic        validOut,
  input  logic        readyIn,
  output logic        orphanCount
);

  typedef enum logic {IDLE, REPEAT} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_dat, w_dat_nxt;
  logic [31:0]      r_last, w_last_nxt;
  logic             r_vld, w_vld_nxt;
  logic             r_seen, w_seen_nxt;
  logic             r_orphan, w_orphan_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic             w_slot_free;
  logic             w_acc;
  logic             w_flag;
  logic [31:0]      w_field;

  always_comb begin
    w_flag  = dataIn[31];
    w_field = {1'b0, dataIn[30:0]};
    if (disabledGroups == 4'b1110) begin
      w_flag  = dataIn[7];
      w_field = {25'd0, dataIn[6:0]};
    end else if (disabledGroups == 4'b1100) begin
      w_flag  = dataIn[15];
      w_field = {17'd0, dataIn[14:0]};
    end
  end

  assign w_cnt       = CNT_W'(w_field[30:0]);
  assign w_slot_free = !r_vld || readyIn;
  assign readyOut    = (r_state == IDLE) && w_slot_free;
  assign w_acc       = validIn && readyOut;

  always_comb begin
    w_state_nxt  = r_state;
    w_dat_nxt    = r_dat;
    w_vld_nxt    = r_vld;
    w_last_nxt   = r_last;
    w_rem_nxt    = r_rem;
    w_seen_nxt   = r_seen;
    w_orphan_nxt = r_orphan;
    if (w_slot_free) begin
      w_vld_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            if (!enable) begin
              w_dat_nxt = dataIn;
              w_vld_nxt = 1'b1;
            end else if (!w_flag) begin
              w_dat_nxt  = w_field;
              w_vld_nxt  = 1'b1;
              w_last_nxt = w_field;
              w_seen_nxt = 1'b1;
            end else begin
              // last is still zero if no literal has arrived, so an orphan run emits zeros
              if (!r_seen) w_orphan_nxt = 1'b1;
              if (w_cnt != '0) begin
                w_dat_nxt = r_last;
                w_vld_nxt = 1'b1;
                w_rem_nxt = w_cnt - CNT_W'(1);
                if (w_cnt > CNT_W'(1)) w_state_nxt = REPEAT;
              end
            end
          end
        end
        REPEAT: begin
          w_dat_nxt = r_last;
          w_vld_nxt = 1'b1;
          w_rem_nxt = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_dat    <= '0;
      r_vld    <= 1'b0;
      r_last   <= '0;
      r_rem    <= '0;
      r_seen   <= 1'b0;
      r_orphan <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dat    <= w_dat_nxt;
      r_vld    <= w_vld_nxt;
      r_last   <= w_last_nxt;
      r_rem    <= w_rem_nxt;
      r_seen   <= w_seen_nxt;
      r_orphan <= w_orphan_nxt;
    end
  end

  assign dataOut     = r_dat;
  assign validOut    = r_vld;
  assign orphanCount = r_orphan;

endmodule

// File: tb/tb_rle_dec.sv
// Directed bench for rle_dec: inputs change 1 time unit after the rising edge, outputs are observed at the falling edge.
module tb_rle_dec;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  disabledGroups;
  logic [31:0] dataIn;
  logic        validIn;
  logic        readyOut;
  logic [31:0] dataOut;
  logic        validOut;
  logic        readyIn;
  logic        orphanCount;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int obs_cnt = 0;
  int lo_cnt  = 0;
  int cnt7f   = 0;
  logic [31:0] obs_dat [256];
  int          obs_cyc [256];

  always #5 clock = ~clock;

  rle_dec #(.CNT_W(31)) dut (
    .clock(clock), .reset(reset), .enable(enable), .disabledGroups(disabledGroups),
    .dataIn(dataIn), .validIn(validIn), .readyOut(readyOut),
    .dataOut(dataOut), .validOut(validOut), .readyIn(readyIn), .orphanCount(orphanCount)
  );

  // Records every transfer that will occur at the coming rising edge.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (reset && !readyOut) lo_cnt <= lo_cnt + 1;
    if (reset && validOut && readyIn) begin
      obs_dat[obs_cnt[7:0]] <= dataOut;
      obs_cyc[obs_cnt[7:0]] <= cyc + 1;
      obs_cnt <= obs_cnt + 1;
      if (dataOut == 32'h7FFF_FFFF) cnt7f <= cnt7f + 1;
    end
  end

  function automatic logic [31:0] od(input int k);
    logic [7:0] ix;
    ix = k[7:0];
    return obs_dat[ix];
  endfunction

  function automatic int oc(input int k);
    logic [7:0] ix;
    ix = k[7:0];
    return obs_cyc[ix];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic en, input logic [3:0] dg, output int acc);
    dataIn = w;
    enable = en;
    disabledGroups = dg;
    validIn = 1'b1;
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock); #1;
      if (readyOut) begin
        acc = cyc;
        break;
      end
    end
    chk("send_accept", 32'(acc >= 0), 32'd1);
    if (acc >= 0) begin
      @(posedge clock); #1;
    end
    validIn = 1'b0;
  endtask

  initial begin
    int n0, lo0, c7, acc, a0, a1, wi;
    logic [5:0]  pat;
    logic [31:0] held;
    logic        stalled;

    reset = 1'b0; enable = 1'b0; disabledGroups = 4'd0;
    dataIn = '0; validIn = 1'b0; readyIn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_validOut", 32'(validOut), 32'd0);
    chk("rst_dataOut", dataOut, 32'd0);
    chk("rst_orphan", 32'(orphanCount), 32'd0);
    chk("rst_readyOut", 32'(readyOut), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;

    // 8-bit literal, count 5, literal
    n0 = obs_cnt; lo0 = lo_cnt;
    send(32'h41, 1'b1, 4'b1110, acc);
    send(32'h85, 1'b1, 4'b1110, acc);
    send(32'h42, 1'b1, 4'b1110, acc);
    repeat (4) @(posedge clock);
    #1;
    chk("t1_count", obs_cnt - n0, 32'd7);
    for (int i = 0; i < 6; i++) chk("t1_rep", od(n0 + i), 32'h41);
    chk("t1_last", od(n0 + 6), 32'h42);
    chk("t1_span", oc(n0 + 6) - oc(n0), 32'd6);
    chk("t1_rdy_lo", lo_cnt - lo0, 32'd4);
    chk("t1_orphan", 32'(orphanCount), 32'd0);

    // 16-bit, zero count is consumed silently
    n0 = obs_cnt;
    send(32'h1234, 1'b1, 4'b1100, acc);
    send(32'h8000, 1'b1, 4'b1100, acc);
    send(32'h8003, 1'b1, 4'b1100, acc);
    send(32'h0055, 1'b1, 4'b1100, acc);
    repeat (4) @(posedge clock);
    #1;
    chk("t2_count", obs_cnt - n0, 32'd5);
    for (int i = 0; i < 4; i++) chk("t2_rep", od(n0 + i), 32'h1234);
    chk("t2_last", od(n0 + 4), 32'h55);

    // 32-bit, long run of 65536 repeats
    n0 = obs_cnt; c7 = cnt7f;
    send(32'h7FFF_FFFF, 1'b1, 4'b0000, acc);
    send(32'h8001_0000, 1'b1, 4'b0000, acc);
    acc = -1;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clock); #1;
      if (readyOut) begin
        acc = k;
        break;
      end
    end
    chk("t3_done", 32'(acc >= 0), 32'd1);
    chk("t3_cnt_at_ready", obs_cnt - n0, 32'd65537);
    repeat (3) @(posedge clock);
    #1;
    chk("t3_total", obs_cnt - n0, 32'd65537);
    chk("t3_values", cnt7f - c7, 32'd65537);

    // backpressure on the output side
    n0 = obs_cnt; pat = 6'b101001; wi = 0; stalled = 1'b0; held = '0;
    enable = 1'b1; disabledGroups = 4'b1110;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) readyIn = pat[i];
      else readyIn = 1'b1;
      dataIn = (wi == 0) ? 32'h41 : 32'h83;
      validIn = (wi < 2);
      @(negedge clock); #1;
      if (stalled) begin
        chk("t4_hold_dat", dataOut, held);
        chk("t4_hold_vld", 32'(validOut), 32'd1);
      end
      stalled = validOut && !readyIn;
      held = dataOut;
      if (validIn && readyOut) wi++;
      @(posedge clock); #1;
    end
    validIn = 1'b0; readyIn = 1'b1;
    chk("t4_accepted", wi, 32'd2);
    chk("t4_count", obs_cnt - n0, 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_val", od(n0 + i), 32'h41);

    // pass-through
    n0 = obs_cnt;
    send(32'h8000_0005, 1'b0, 4'b1110, a0);
    send(32'hFFFF_FFFF, 1'b0, 4'b1110, a1);
    repeat (3) @(posedge clock);
    #1;
    chk("t5_count", obs_cnt - n0, 32'd2);
    chk("t5_w0", od(n0), 32'h8000_0005);
    chk("t5_w1", od(n0 + 1), 32'hFFFF_FFFF);
    chk("t5_lat0", oc(n0) - a0, 32'd1);
    chk("t5_lat1", oc(n0 + 1) - a1, 32'd1);
    chk("t5_orphan", 32'(orphanCount), 32'd0);

    // orphan count after reset, then reset mid-run
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("t6_orphan_clr", 32'(orphanCount), 32'd0);
    n0 = obs_cnt;
    send(32'h82, 1'b1, 4'b1110, acc);
    repeat (3) @(posedge clock);
    #1;
    chk("t6_orphan_cnt", obs_cnt - n0, 32'd2);
    chk("t6_orphan_v0", od(n0), 32'h0);
    chk("t6_orphan_v1", od(n0 + 1), 32'h0);
    chk("t6_orphan_flag", 32'(orphanCount), 32'd1);

    n0 = obs_cnt;
    send(32'h41, 1'b1, 4'b1110, acc);
    send(32'hFF, 1'b1, 4'b1110, acc);
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock); #1;
      if (obs_cnt - n0 >= 10) begin
        acc = k;
        break;
      end
    end
    chk("t6_ten_outputs", 32'(acc >= 0), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_abort_vld", 32'(validOut), 32'd0);
    chk("t6_abort_dat", dataOut, 32'd0);
    chk("t6_abort_orphan", 32'(orphanCount), 32'd0);
    chk("t6_abort_rdy", 32'(readyOut), 32'd1);
    n0 = obs_cnt;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("t6_quiet_cnt", obs_cnt - n0, 32'd0);
    chk("t6_quiet_vld", 32'(validOut), 32'd0);
    send(32'h43, 1'b1, 4'b1110, acc);
    repeat (2) @(posedge clock);
    #1;
    chk("t6_resume_cnt", obs_cnt - n0, 32'd1);
    chk("t6_resume_val", od(n0), 32'h43);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
